// File: rtl/countdown.sv
// Loadable down-counter that clamps loads to [Floor, Init], counts toward Floor
// under En_i, and pulses Done_o once when a decrement lands on Floor.
module countdown #(
  parameter logic [31:0] Init  = 32'd64,
  parameter logic [31:0] Floor = 32'd8
) (
  input  logic        Clk_i,
  input  logic        Reset_n_i,
  input  logic        En_i,
  input  logic        Load_valid_i,
  input  logic [31:0] Load_data_i,
  output logic        Load_ready_o,
  output logic [31:0] Data_o,
  output logic        Empty_o,
  output logic        Done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] data_next;
  logic        empty_next;
  logic        done_next;
  logic        load_accept;
  logic        dec_accept;
  logic [31:0] load_clamped;
  logic [31:0] data_minus_one;

  // Ready depends only on the registered state, so it is glitch-free.
  assign Load_ready_o = (state != COUNT);

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      state   <= IDLE;
      Data_o  <= Init;
      Empty_o <= 1'b0;
      Done_o  <= 1'b0;
    end else begin
      state   <= state_next;
      Data_o  <= data_next;
      Empty_o <= empty_next;
      Done_o  <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    data_next      = Data_o;
    done_next      = 1'b0;
    load_clamped   = Load_data_i;
    data_minus_one = Data_o - 32'd1;

    if (Load_data_i < Floor) begin
      load_clamped = Floor;
    end else if (Load_data_i > Init) begin
      load_clamped = Init;
    end

    // A load wins over a decrement; HOLD never decrements since Data_o is at Floor.
    load_accept = Load_valid_i && (state != COUNT);
    dec_accept  = !load_accept && En_i && (Data_o > Floor) &&
                  ((state == IDLE) || (state == COUNT));

    if (load_accept) begin
      data_next  = load_clamped;
      state_next = (load_clamped > Floor) ? IDLE : HOLD;
    end else if (dec_accept) begin
      data_next  = data_minus_one;
      state_next = (data_minus_one > Floor) ? COUNT : HOLD;
      done_next  = (data_minus_one == Floor);
    end

    empty_next = (data_next == Floor);
  end

endmodule

// File: tb/tb_countdown.sv
// Directed-vector bench for countdown: a table of per-cycle stimulus/expectation
// records plus hand-written reset-during-count sequences.
module tb_countdown;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [31:0] data;
  logic        empty;
  logic        done;

  int checks;
  int failures;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        lv;
    logic [31:0] ld;
    logic [31:0] e_data;
    logic        e_ready;
    logic        e_empty;
    logic        e_done;
    string       name;
  } vec_t;

  vec_t vecs[$];

  countdown #(.Init(32'd64), .Floor(32'd8)) dut (
    .Clk_i        (clk),
    .Reset_n_i    (reset_n),
    .En_i         (en),
    .Load_valid_i (load_valid),
    .Load_data_i  (load_data),
    .Load_ready_o (load_ready),
    .Data_o       (data),
    .Empty_o      (empty),
    .Done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(logic rst_n, logic e, logic lv, logic [31:0] ld,
                                 logic [31:0] ed, logic er, logic ee, logic edn,
                                 string name);
    vec_t v;
    v.rst_n = rst_n; v.en = e; v.lv = lv; v.ld = ld;
    v.e_data = ed; v.e_ready = er; v.e_empty = ee; v.e_done = edn;
    v.name = name;
    vecs.push_back(v);
  endfunction

  // Inputs change 1 time unit after the edge and outputs are sampled there too.
  task automatic applyStimulus(input logic rst_n, input logic e, input logic lv,
                               input logic [31:0] ld);
    reset_n    = rst_n;
    en         = e;
    load_valid = lv;
    load_data  = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] ed,
                             input logic er, input logic ee, input logic edn);
    checks++;
    if (data !== ed) begin
      failures++;
      $display("[TB] FAIL %s data: got %0d expected %0d", name, data, ed);
    end
    checks++;
    if (load_ready !== er) begin
      failures++;
      $display("[TB] FAIL %s load_ready: got %b expected %b", name, load_ready, er);
    end
    checks++;
    if (empty !== ee) begin
      failures++;
      $display("[TB] FAIL %s empty: got %b expected %b", name, empty, ee);
    end
    checks++;
    if (done !== edn) begin
      failures++;
      $display("[TB] FAIL %s done: got %b expected %b", name, done, edn);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'd0;

    addVec(0, 0, 0, 0, 64, 1, 0, 0, "reset1");
    addVec(0, 0, 0, 0, 64, 1, 0, 0, "reset2");
    for (int i = 63; i >= 8; i--)
      addVec(1, 1, 0, 0, i, (i == 8), (i == 8), (i == 8), "countdown");
    for (int i = 0; i < 3; i++)
      addVec(1, 1, 0, 0, 8, 1, 1, 0, "hold_stays");
    addVec(1, 1, 1, 20, 20, 1, 0, 0, "hold_load20");
    for (int i = 19; i >= 8; i--)
      addVec(1, 1, 0, 0, i, (i == 8), (i == 8), (i == 8), "count_from20");
    addVec(1, 0, 1, 100, 64, 1, 0, 0, "load100_clamp");
    addVec(1, 1, 1, 50, 50, 1, 0, 0, "load_beats_dec");
    for (int i = 49; i >= 40; i--)
      addVec(1, 1, 0, 0, i, 0, 0, 0, "count_to40");
    for (int i = 0; i < 3; i++)
      addVec(1, 0, 1, 20, 40, 0, 0, 0, "pause_ignore_load");
    addVec(1, 1, 0, 0, 39, 0, 0, 0, "resume");
    addVec(0, 1, 1, 20, 64, 1, 0, 0, "reset_over_load");
    addVec(1, 0, 1, 3, 8, 1, 1, 0, "load3_clamp");
    addVec(1, 1, 0, 0, 8, 1, 1, 0, "floor_no_dec");
    addVec(1, 0, 1, 100, 64, 1, 0, 0, "load100_again");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].lv, vecs[i].ld);
      checkOutput(vecs[i].name, vecs[i].e_data, vecs[i].e_ready,
                  vecs[i].e_empty, vecs[i].e_done);
    end

    // Reset while counting at 30.
    for (int i = 63; i >= 30; i--)
      applyStimulus(1, 1, 0, 0);
    checkOutput("at30", 30, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("reset_at30", 64, 1, 0, 0);

    // Reset on the edge that would otherwise reach Floor.
    applyStimulus(1, 0, 1, 10);
    checkOutput("load10", 10, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("dec_to9", 9, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("reset_kills_done", 64, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("after_reset_quiet", 64, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
